// File: rtl/dmem_bus_responder.sv
// dmem_bus_responder: data-bus target with word RAM, wait-state FSM, mem_ready handshake and bus_err pulse; ports clk, rst (async active-low), AddressBus/DataBusOut/ControlBus in, DataBusIn/mem_ready/bus_err out; optional DMEM_STATS_EN adds rd/wr/err counters at 0xFFFFFFF0..F2 (clear at F3)
module dmem_bus_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AddressBus,
  input  logic [31:0] DataBusOut,
  input  logic [2:0]  ControlBus,
  output logic [31:0] DataBusIn,
  output logic        mem_ready,
  output logic        bus_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  logic [31:0] ram [2**ADDR_BITS];
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic we_q, we_d, both_q, both_d, err_q, err_d;
  logic req, in_idle, in_range, fire, ram_we, cur_we, cur_both;
  logic [31:0] cur_addr, cur_wdata, rd_val;
  logic stat_rd, stat_clr;
  logic [31:0] stat_val;
  logic unused_ctl;
  assign unused_ctl = ControlBus[0];
  always_comb begin
    req       = ControlBus[2] | ControlBus[1];
    in_idle   = state_q == S_IDLE;
    // IDLE acts on the live bus (zero-wait path); WAIT uses the latched request
    cur_addr  = in_idle ? AddressBus : addr_q;
    cur_wdata = in_idle ? DataBusOut : wdata_q;
    cur_we    = in_idle ? ControlBus[2] : we_q;
    cur_both  = in_idle ? &ControlBus[2:1] : both_q;
    in_range  = cur_addr[31:ADDR_BITS] == '0;
    fire      = rst & req & (in_idle ? (WAIT_CYCLES == 0) : (state_q == S_WAIT && cnt_q == 4'd0));
    ram_we    = fire & cur_we & in_range;
    rd_val    = in_range ? ram[cur_addr[ADDR_BITS-1:0]] : stat_rd ? stat_val : ERR_DATA;
    data_d    = (fire & ~cur_we) ? rd_val : data_q;
    err_d     = fire & (cur_both | ~(in_range | stat_rd | stat_clr));
    addr_d    = (in_idle & req) ? AddressBus : addr_q;
    wdata_d   = (in_idle & req) ? DataBusOut : wdata_q;
    we_d      = (in_idle & req) ? ControlBus[2] : we_q;
    both_d    = (in_idle & req) ? &ControlBus[2:1] : both_q;
    cnt_d     = in_idle ? WLOAD : cnt_q - {3'd0, cnt_q != 4'd0};
    state_d   = state_q == S_RESP ? S_IDLE :
                !req ? S_IDLE :
                fire ? S_RESP :
                S_WAIT;
    mem_ready = rst & (in_idle ? ~req : state_q == S_RESP);
  end
`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;
  logic clr_fire;
  always_comb begin
    stat_rd   = ~cur_we & (cur_addr == 32'hFFFFFFF0 | cur_addr == 32'hFFFFFFF1 | cur_addr == 32'hFFFFFFF2);
    stat_clr  = cur_we & cur_addr == 32'hFFFFFFF3;
    stat_val  = cur_addr[1:0] == 2'd0 ? rd_cnt_q : cur_addr[1:0] == 2'd1 ? wr_cnt_q : err_cnt_q;
    clr_fire  = fire & stat_clr;
    // counters saturate rather than wrap
    rd_cnt_d  = clr_fire ? '0 : rd_cnt_q + {31'd0, fire & ~cur_we & (in_range | stat_rd) & ~&rd_cnt_q};
    wr_cnt_d  = clr_fire ? '0 : wr_cnt_q + {31'd0, ram_we & ~&wr_cnt_q};
    err_cnt_d = clr_fire ? '0 : err_cnt_q + {31'd0, err_d & ~&err_cnt_q};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
`else
  assign stat_rd  = 1'b0;
  assign stat_clr = 1'b0;
  assign stat_val = '0;
`endif
  always_ff @(posedge clk)
    if (ram_we) ram[cur_addr[ADDR_BITS-1:0]] <= cur_wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      both_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      both_q  <= both_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  assign DataBusIn = data_q;
  assign bus_err   = err_q;
endmodule

// File: tb/tb_dmem_bus_responder.sv
// tb_dmem_bus_responder: randomized check of zero-wait and 3-wait responders against a word-array reference model
module tb_dmem_bus_responder;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [31:0] addr [2], dout [2], din [2];
  logic [2:0] ctl [2];
  logic rdy [2], err [2];
  dmem_bus_responder #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .AddressBus(addr[0]), .DataBusOut(dout[0]),
    .ControlBus(ctl[0]), .DataBusIn(din[0]), .mem_ready(rdy[0]), .bus_err(err[0]));
  dmem_bus_responder #(.WAIT_CYCLES(3)) u1 (.clk(clk), .rst(rst), .AddressBus(addr[1]), .DataBusOut(dout[1]),
    .ControlBus(ctl[1]), .DataBusIn(din[1]), .mem_ready(rdy[1]), .bus_err(err[1]));
  int n_chk = 0, n_pass = 0;
  int wc [2] = '{0, 3};
  logic [31:0] mdl [2][1024];
  logic [31:0] exp_din [2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] v, input logic [2:0] c, input int abort_at);
    bit inr, we;
    inr = a < 32'd1024;
    we  = c[2];
    @(negedge clk);
    chk("idle_rdy", 32'(rdy[d]), 1);
    chk("idle_err", 32'(err[d]), 0);
    chk("idle_din", din[d], exp_din[d]);
    addr[d] = a;
    dout[d] = v;
    ctl[d]  = c;
    #1 chk("req_rdy", 32'(rdy[d]), 0);
    for (int k = 0; k < wc[d]; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("wait_rdy", 32'(rdy[d]), 0);
      chk("wait_err", 32'(err[d]), 0);
      if (k + 1 == abort_at) begin
        ctl[d] = 3'b000;
        @(negedge clk);
        chk("abort_rdy", 32'(rdy[d]), 1);
        chk("abort_din", din[d], exp_din[d]);
        return;
      end
      addr[d] = $urandom;
      dout[d] = $urandom;
    end
    @(posedge clk);
    @(negedge clk);
    if (we && inr) mdl[d][a[9:0]] = v;
    if (!we) exp_din[d] = inr ? mdl[d][a[9:0]] : 32'hDEADBEEF;
    chk("resp_rdy", 32'(rdy[d]), 1);
    chk("resp_err", 32'(err[d]), 32'((c[2] & c[1]) | !inr));
    chk("resp_din", din[d], exp_din[d]);
    ctl[d] = 3'b000;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      addr[d] = 0; dout[d] = 0; ctl[d] = 0; exp_din[d] = 0;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdy", 32'(rdy[d]), 0);
      chk("rst_din", din[d], 0);
      chk("rst_err", 32'(err[d]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++) txn(d, a, $urandom, 3'b100, -1);
    txn(0, 5, 32'h12345678, 3'b100, -1);
    txn(0, 5, 0, 3'b010, -1);
    chk("zw_read5", din[0], 32'h12345678);
    txn(1, 7, 0, 3'b010, -1);
    chk("ws_read7", din[1], mdl[1][7]);
    txn(1, 9, 32'hAAAA5555, 3'b100, 1);
    txn(1, 9, 0, 3'b010, -1);
    for (int d = 0; d < 2; d++) begin
      txn(d, 32'h400, 0, 3'b010, -1);
      chk("oor_data", din[d], 32'hDEADBEEF);
      txn(d, 2, 32'hC0FFEE00 + d, 3'b110, -1);
      txn(d, 2, 0, 3'b011, -1);
      txn(d, 32'h8000_0003, 32'h1, 3'b100, -1);
    end
    // reset in the middle of a waited write must discard it
    @(negedge clk);
    addr[1] = 11; dout[1] = 32'h5A5A5A5A; ctl[1] = 3'b100;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_rdy", 32'(rdy[d]), 0);
      chk("mid_rst_din", din[d], 0);
      exp_din[d] = 0;
    end
    ctl[1] = 0;
    @(negedge clk);
    rst = 1;
    txn(1, 11, 0, 3'b010, -1);
    for (int i = 0; i < 300; i++) begin
      int d, sel, ab;
      logic [31:0] a;
      logic [2:0] c;
      d   = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      a   = sel == 0 ? 32'h400 + $urandom_range(0, 50) : sel == 1 ? ($urandom | 32'h8000_0000) : $urandom_range(0, 31);
      c   = {2'($urandom_range(1, 3)), 1'($urandom_range(0, 1))};
      ab  = (d == 1 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : -1;
      txn(d, a, $urandom, c, ab);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
